// File: rtl/alu_8bit_if.sv
// alu_8bit_if: operand/opcode and result/flag bundle for the registered 8-bit ALU.
// The master side drives A, B and AluOp and observes the registered outputs;
// the slave side (the ALU) does the reverse.
// Optional feature macro: ALU_CARRY_OUT_EN adds the Carry signal to the bundle.
interface alu_8bit_if;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] AluOp;
    logic [7:0] Result;
    logic       Zero;
    logic       Negative;
    logic       Overflow;
`ifdef ALU_CARRY_OUT_EN
    logic       Carry;
`endif

    modport master (
        output A, B, AluOp,
        input  Result, Zero, Negative, Overflow
`ifdef ALU_CARRY_OUT_EN
        , input Carry
`endif
    );

    modport slave (
        input  A, B, AluOp,
        output Result, Zero, Negative, Overflow
`ifdef ALU_CARRY_OUT_EN
        , output Carry
`endif
    );
endinterface

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU for the execute stage.
// Operands and opcode are sampled on a rising clk edge and the result plus
// Zero/Negative/Overflow flags appear right after that edge, held for one cycle.
// A new operation is accepted every cycle; rst_n is synchronous and active-low.
// Optional feature macro: ALU_CARRY_OUT_EN adds a registered unsigned carry/borrow
// output (Carry) to the interface; without it the port does not exist.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    alu_8bit_if.slave  bus
);

    logic [7:0] result_next;
    logic       overflow_next;

    // Next result and signed-overflow flag, purely combinational from the current operands
    always_comb begin
        result_next   = 8'h00;
        overflow_next = 1'b0;
        case (bus.AluOp)
            4'b0000: begin
                result_next   = bus.A + bus.B;
                overflow_next = (bus.A[7] == bus.B[7]) && (result_next[7] != bus.A[7]);
            end
            4'b0001: begin
                result_next   = bus.B - bus.A;
                overflow_next = (bus.B[7] != bus.A[7]) && (result_next[7] != bus.B[7]);
            end
            4'b0010: begin
                result_next   = bus.A + 8'd1;
                overflow_next = (bus.A == 8'h7F);
            end
            4'b0011: begin
                result_next   = bus.A - 8'd1;
                overflow_next = (bus.A == 8'h80);
            end
            4'b0100: begin
                result_next   = bus.A - bus.B;
                overflow_next = (bus.A[7] != bus.B[7]) && (result_next[7] != bus.A[7]);
            end
            4'b0101: result_next = (bus.A == bus.B) ? 8'h01 : 8'h00;
            4'b0110: result_next = {bus.A[6:0], 1'b0};
            4'b0111: result_next = {1'b0, bus.A[7:1]};
            4'b1000: result_next = ~bus.A;
            4'b1001: result_next = bus.A & bus.B;
            4'b1010: result_next = bus.A | bus.B;
            4'b1011: result_next = ~(bus.A & bus.B);
            4'b1100: result_next = {bus.A[6:0], bus.A[7]};
            4'b1101: result_next = {bus.A[0], bus.A[7:1]};
            4'b1110: result_next = bus.A ^ bus.B;
            4'b1111: result_next = bus.A;
        endcase
    end

    // Output register: reset wins over any op issued in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Result   <= 8'h00;
            bus.Zero     <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Overflow <= 1'b0;
        end else begin
            bus.Result   <= result_next;
            bus.Zero     <= (result_next == 8'h00);
            bus.Negative <= result_next[7];
            bus.Overflow <= overflow_next;
        end
    end

`ifdef ALU_CARRY_OUT_EN
    logic carry_next;

    // Unsigned carry for add/increment, borrow for subtracts, shifted-out bit for shifts
    always_comb begin
        carry_next = 1'b0;
        case (bus.AluOp)
            4'b0000: carry_next = (({1'b0, bus.A} + {1'b0, bus.B}) > 9'd255);
            4'b0001: carry_next = (bus.B < bus.A);
            4'b0010: carry_next = (bus.A == 8'hFF);
            4'b0011: carry_next = (bus.A == 8'h00);
            4'b0100: carry_next = (bus.A < bus.B);
            4'b0110: carry_next = bus.A[7];
            4'b0111: carry_next = bus.A[0];
            default: carry_next = 1'b0;
        endcase
    end

    // Carry register, cleared by the same synchronous reset as the other outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Carry <= 1'b0;
        end else begin
            bus.Carry <= carry_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: self-checking bench for alu_8bit.
// An integer-arithmetic model predicts every registered output; one compare process
// checks the DUT against it on each falling edge, and directed vectors add
// hand-computed literal expectations that pin the model.
// Optional feature macro: ALU_CARRY_OUT_EN also checks the Carry output.
module tb_alu_8bit;

    logic clk;
    logic rst_n;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run;
    int tests_failed;

    // Model state: what the registered outputs must hold after the latest rising edge
    logic [7:0] exp_r;
    logic       exp_z;
    logic       exp_n;
    logic       exp_o;
    logic       exp_c;
    logic       model_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU model using plain integer arithmetic on unsigned and signed views
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                  output logic [7:0] r, output logic o, output logic c);
        int ua;
        int ub;
        int sa;
        int sb;
        int u;
        int s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        u = 0;
        s = 0;
        r = 8'h00;
        o = 1'b0;
        c = 1'b0;
        case (op)
            4'h0: begin u = ua + ub; s = sa + sb; end
            4'h1: begin u = ub - ua; s = sb - sa; end
            4'h2: begin u = ua + 1;  s = sa + 1;  end
            4'h3: begin u = ua - 1;  s = sa - 1;  end
            4'h4: begin u = ua - ub; s = sa - sb; end
            4'h5: r = (ua == ub) ? 8'd1 : 8'd0;
            4'h6: begin r = 8'((ua * 2) % 256); c = (ua >= 128); end
            4'h7: begin r = 8'(ua / 2); c = (ua % 2 == 1); end
            4'h8: r = 8'(255 - ua);
            4'h9: r = a & b;
            4'hA: r = a | b;
            4'hB: r = ~(a & b);
            4'hC: r = 8'((ua * 2) % 256 + ua / 128);
            4'hD: r = 8'(ua / 2 + (ua % 2) * 128);
            4'hE: r = a ^ b;
            default: r = a;
        endcase
        if (op <= 4'h4) begin
            r = 8'(u);
            o = (s > 127) || (s < -128);
            c = (op == 4'h0 || op == 4'h2) ? (u > 255) : (u < 0);
        end
    endfunction

    // One comparison: counts it and reports any difference
    task automatic compareField(input string name, input logic [7:0] got, input logic [7:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
        end
    endtask

    // Model update on every rising edge, sampling the same inputs the DUT sees
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_r = 8'h00;
            exp_o = 1'b0;
            exp_c = 1'b0;
            exp_z = 1'b0;
            exp_n = 1'b0;
        end else begin
            model(bus.A, bus.B, bus.AluOp, exp_r, exp_o, exp_c);
            exp_z = (exp_r == 8'h00);
            exp_n = exp_r[7];
        end
        model_valid = 1'b1;
    end

    // Compare process: DUT outputs against the model, mid-cycle
    always @(negedge clk) begin
        if (model_valid) begin
            compareField("model_result",   bus.Result,          exp_r);
            compareField("model_zero",     {7'd0, bus.Zero},     {7'd0, exp_z});
            compareField("model_negative", {7'd0, bus.Negative}, {7'd0, exp_n});
            compareField("model_overflow", {7'd0, bus.Overflow}, {7'd0, exp_o});
`ifdef ALU_CARRY_OUT_EN
            compareField("model_carry",    {7'd0, bus.Carry},    {7'd0, exp_c});
`endif
        end
    end

    // Drive one operation for the next rising edge
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.AluOp = op;
        @(posedge clk);
        #1;
    endtask

    // Literal check of the outputs just after the edge
    task automatic checkOutput(input string name, input logic [7:0] r, input logic z,
                               input logic n, input logic o);
        compareField({name, "_result"},   bus.Result,          r);
        compareField({name, "_zero"},     {7'd0, bus.Zero},     {7'd0, z});
        compareField({name, "_negative"}, {7'd0, bus.Negative}, {7'd0, n});
        compareField({name, "_overflow"}, {7'd0, bus.Overflow}, {7'd0, o});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_valid  = 1'b0;
        rst_n        = 1'b0;
        bus.A        = 8'd5;
        bus.B        = 8'd5;
        bus.AluOp    = 4'b0000;

        // Reset edge with an add pending, then release
        @(posedge clk);
        #1;
        checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_add", 8'd10, 1'b0, 1'b0, 1'b0);

        // Add
        applyStimulus(8'd15, 8'd10, 4'b0000);   checkOutput("add_15_10", 8'd25, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd100, 8'd50, 4'b0000);  checkOutput("add_100_50", 8'd150, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'd0, 8'd0, 4'b0000);     checkOutput("add_0_0", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'd255, 8'd1, 4'b0000);   checkOutput("add_255_1", 8'd0, 1'b1, 1'b0, 1'b0);

        // Subtract B-A and A-B
        applyStimulus(8'd10, 8'd25, 4'b0001);   checkOutput("bsub_10_25", 8'd15, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd30, 8'd10, 4'b0001);   checkOutput("bsub_30_10", 8'd236, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'd20, 8'd20, 4'b0001);   checkOutput("bsub_20_20", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 4'b0100);   checkOutput("asub_80_01", 8'h7F, 1'b0, 1'b0, 1'b1);

        // Increment, decrement, set-on-equal
        applyStimulus(8'd42, 8'd0, 4'b0010);    checkOutput("inc_42", 8'd43, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd255, 8'd9, 4'b0010);   checkOutput("inc_255", 8'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'd127, 8'd0, 4'b0010);   checkOutput("inc_127", 8'd128, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h80, 8'd0, 4'b0011);    checkOutput("dec_80", 8'h7F, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'd77, 8'd77, 4'b0101);   checkOutput("eq_77_77", 8'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd77, 8'd78, 4'b0101);   checkOutput("eq_77_78", 8'd0, 1'b1, 1'b0, 1'b0);

        // Shift and rotate
        applyStimulus(8'b00001111, 8'hFF, 4'b0110); checkOutput("shl", 8'b00011110, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'b11110000, 8'hFF, 4'b0111); checkOutput("shr", 8'b01111000, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'b10000001, 8'h00, 4'b1100); checkOutput("rotl", 8'b00000011, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'b10000001, 8'h00, 4'b1101); checkOutput("rotr", 8'b11000000, 1'b0, 1'b1, 1'b0);

        // Logic
        applyStimulus(8'b10101010, 8'h00, 4'b1000);       checkOutput("not", 8'b01010101, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'b11110000, 8'b10101010, 4'b1001); checkOutput("and_a", 8'b10100000, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'b11110000, 8'b00001111, 4'b1001); checkOutput("and_b", 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'b11110000, 8'b00001111, 4'b1010); checkOutput("or", 8'hFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'b11110000, 8'b10101010, 4'b1011); checkOutput("nand", 8'b01011111, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'b11110000, 8'b10101010, 4'b1110); checkOutput("xor", 8'b01011010, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h9C, 8'h11, 4'b1111);             checkOutput("pass", 8'h9C, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of traffic overrides an overflowing add
        @(negedge clk);
        rst_n     = 1'b0;
        bus.A     = 8'd100;
        bus.B     = 8'd50;
        bus.AluOp = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Every op against a set of operand corners, back-to-back, checked by the model
        for (int op = 0; op < 16; op++) begin
            applyStimulus(8'h7F, 8'h80, 4'(op));
            applyStimulus(8'h80, 8'h7F, 4'(op));
            applyStimulus(8'hFF, 8'hFF, 4'(op));
            applyStimulus(8'h00, 8'h01, 4'(op));
            applyStimulus(8'h01, 8'h00, 4'(op));
            applyStimulus(8'h5A, 8'hC3, 4'(op));
        end

        // A stretch of mixed operations for the model to follow
        for (int i = 0; i < 200; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
